// File: rtl/commit_trace_monitor_if.sv
// Commit-side trace bus: per-slot debug commit signals plus the drained trace stream.
interface commit_trace_monitor_if #(
    parameter int unsigned NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]      cm_valid;
    logic [32*NUM_PORTS-1:0]   cm_pc;
    logic [5*NUM_PORTS-1:0]    cm_dest;
    logic [4*NUM_PORTS-1:0]    cm_wstrb;
    logic [32*NUM_PORTS-1:0]   cm_wdata;
    logic [NUM_PORTS-1:0]      cm_br_op;
    logic [NUM_PORTS-1:0]      cm_pred_ok;

    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_pc;
    logic [4:0]                out_dest;
    logic [31:0]               out_wdata;

    // Pipeline/consumer side: drives commits and accepts the trace stream.
    modport master (
        output cm_valid, cm_pc, cm_dest, cm_wstrb, cm_wdata, cm_br_op, cm_pred_ok,
        output out_ready,
        input  out_valid, out_pc, out_dest, out_wdata
    );

    // Monitor side.
    modport slave (
        input  cm_valid, cm_pc, cm_dest, cm_wstrb, cm_wdata, cm_br_op, cm_pred_ok,
        input  out_ready,
        output out_valid, out_pc, out_dest, out_wdata
    );
endinterface

// File: rtl/commit_trace_monitor.sv
// Commit trace monitor: serialises qualifying register writes of all commit slots into a
// FIFO in program order, keeps saturating IPC/branch counters and freezes at END_PC.
module commit_trace_monitor #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] END_PC    = 32'hbfc00100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trace_en,
    input  logic                  cnt_clear,
    commit_trace_monitor_if.slave bus,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  done,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      inst_cnt,
    output logic [CNT_W-1:0]      br_cnt,
    output logic [CNT_W-1:0]      br_hit
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    // One extra bit so occupancy + pushes cannot wrap before the compare.
    localparam logic [OCC_W:0] DEPTH_X = (OCC_W + 1)'(DEPTH);
    localparam logic [OCC_W:0] PORTS_X = (OCC_W + 1)'(NUM_PORTS);

    logic [31:0]          mem_pc   [DEPTH];
    logic [4:0]           mem_dest [DEPTH];
    logic [31:0]          mem_data [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 almost_full_q, almost_full_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     inst_q, inst_d;
    logic [CNT_W-1:0]     br_q, br_d;
    logic [CNT_W-1:0]     hit_q, hit_d;

    logic [NUM_PORTS-1:0] qual;
    logic [PTR_W-1:0]     wr_idx  [NUM_PORTS];
    logic [31:0]          wdata_m [NUM_PORTS];
    logic [OCC_W-1:0]     n_qual;
    logic [CNT_W-1:0]     n_valid, n_br, n_hit;
    logic                 end_hit;
    logic                 push, pop, drop;
    logic                 head_valid;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Qualify each slot, mask its data and give it a compacted write slot after older ones.
    always_comb begin
        qual    = '0;
        n_qual  = '0;
        n_valid = '0;
        n_br    = '0;
        n_hit   = '0;
        end_hit = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            wr_idx[i] = wr_ptr_q + n_qual[PTR_W-1:0];
            for (int b = 0; b < 4; b++) begin
                wdata_m[i][8*b +: 8] = bus.cm_wstrb[4*i + b] ? bus.cm_wdata[32*i + 8*b +: 8]
                                                             : 8'h00;
            end
            qual[i] = bus.cm_valid[i] && (bus.cm_wstrb[4*i +: 4] != 4'b0000) &&
                      (bus.cm_dest[5*i +: 5] != 5'd0) && trace_en && !done_q;
            if (qual[i]) begin
                n_qual = n_qual + OCC_W'(1);
            end
            n_valid = n_valid + CNT_W'(bus.cm_valid[i]);
            n_br    = n_br + CNT_W'(bus.cm_valid[i] & bus.cm_br_op[i]);
            n_hit   = n_hit + CNT_W'(bus.cm_valid[i] & bus.cm_br_op[i] & bus.cm_pred_ok[i]);
            if (bus.cm_valid[i] && (bus.cm_pc[32*i +: 32] == END_PC)) begin
                end_hit = 1'b1;
            end
        end
    end

    // FIFO bookkeeping: whole-cycle accept or drop, pop not credited to the fit check.
    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        if (n_qual != '0) begin
            if (({1'b0, occ_q} + {1'b0, n_qual}) > DEPTH_X) begin
                drop = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
        pop   = head_valid && bus.out_ready;
        occ_d = occ_q;
        if (push) begin
            occ_d = occ_d + n_qual;
        end
        if (pop) begin
            occ_d = occ_d - OCC_W'(1);
        end
        wr_ptr_d      = push ? wr_ptr_q + n_qual[PTR_W-1:0] : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        almost_full_d = (DEPTH_X - {1'b0, occ_d}) < PORTS_X;
        overflow_d    = cnt_clear ? 1'b0 : (overflow_q | drop);
        done_d        = cnt_clear ? 1'b0 : (done_q | end_hit);
    end

    // Counters: clear wins, otherwise saturating advance until done.
    always_comb begin
        cycle_d = cycle_q;
        inst_d  = inst_q;
        br_d    = br_q;
        hit_d   = hit_q;
        if (cnt_clear) begin
            cycle_d = '0;
            inst_d  = '0;
            br_d    = '0;
            hit_d   = '0;
        end else if (!done_q) begin
            cycle_d = sat_add(cycle_q, CNT_W'(1));
            inst_d  = sat_add(inst_q, n_valid);
            br_d    = sat_add(br_q, n_br);
            hit_d   = sat_add(hit_q, n_hit);
        end
    end

    // Control and counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            cycle_q       <= '0;
            inst_q        <= '0;
            br_q          <= '0;
            hit_q         <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
            cycle_q       <= cycle_d;
            inst_q        <= inst_d;
            br_q          <= br_d;
            hit_q         <= hit_d;
        end
    end

    // Entry storage; unreset because the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (qual[i]) begin
                    mem_pc[wr_idx[i]]   <= bus.cm_pc[32*i +: 32];
                    mem_dest[wr_idx[i]] <= bus.cm_dest[5*i +: 5];
                    mem_data[wr_idx[i]] <= wdata_m[i];
                end
            end
        end
    end

    assign head_valid    = (occ_q != '0);
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_valid ? mem_pc[rd_ptr_q] : 32'h0;
    assign bus.out_dest  = head_valid ? mem_dest[rd_ptr_q] : 5'd0;
    assign bus.out_wdata = head_valid ? mem_data[rd_ptr_q] : 32'h0;

    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign cycle_cnt   = cycle_q;
    assign inst_cnt    = inst_q;
    assign br_cnt      = br_q;
    assign br_hit      = hit_q;
endmodule

// File: tb/tb_commit_trace_monitor.sv
// Bench for commit_trace_monitor: a DEPTH=16/CNT_W=32 and a DEPTH=4/CNT_W=4 instance share
// one commit stimulus; a per-instance queue holds the entries each should emit.
module tb_commit_trace_monitor;
    localparam logic [31:0] END_PC = 32'hbfc00100;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset, trace_en, cnt_clear;
    logic [1:0]  cm_valid, cm_br_op, cm_pred_ok;
    logic [63:0] cm_pc, cm_wdata;
    logic [9:0]  cm_dest;
    logic [7:0]  cm_wstrb;
    logic [1:0]  ready;

    always #5 clk = ~clk;

    commit_trace_monitor_if #(.NUM_PORTS(2)) bus_a ();
    commit_trace_monitor_if #(.NUM_PORTS(2)) bus_b ();

    assign bus_a.cm_valid   = cm_valid;
    assign bus_a.cm_pc      = cm_pc;
    assign bus_a.cm_dest    = cm_dest;
    assign bus_a.cm_wstrb   = cm_wstrb;
    assign bus_a.cm_wdata   = cm_wdata;
    assign bus_a.cm_br_op   = cm_br_op;
    assign bus_a.cm_pred_ok = cm_pred_ok;
    assign bus_a.out_ready  = ready[0];
    assign bus_b.cm_valid   = cm_valid;
    assign bus_b.cm_pc      = cm_pc;
    assign bus_b.cm_dest    = cm_dest;
    assign bus_b.cm_wstrb   = cm_wstrb;
    assign bus_b.cm_wdata   = cm_wdata;
    assign bus_b.cm_br_op   = cm_br_op;
    assign bus_b.cm_pred_ok = cm_pred_ok;
    assign bus_b.out_ready  = ready[1];

    logic        af_a, ovf_a, done_a;
    logic [31:0] cyc_a, inst_a, brc_a, brh_a;
    logic        af_b, ovf_b, done_b;
    logic [3:0]  cyc_b, inst_b, brc_b, brh_b;

    commit_trace_monitor #(.NUM_PORTS(2), .DEPTH(16), .CNT_W(32), .END_PC(END_PC)) dut_a (
        .clk(clk), .reset(reset), .trace_en(trace_en), .cnt_clear(cnt_clear), .bus(bus_a),
        .almost_full(af_a), .overflow(ovf_a), .done(done_a), .cycle_cnt(cyc_a),
        .inst_cnt(inst_a), .br_cnt(brc_a), .br_hit(brh_a)
    );

    commit_trace_monitor #(.NUM_PORTS(2), .DEPTH(4), .CNT_W(4), .END_PC(END_PC)) dut_b (
        .clk(clk), .reset(reset), .trace_en(trace_en), .cnt_clear(cnt_clear), .bus(bus_b),
        .almost_full(af_b), .overflow(ovf_b), .done(done_b), .cycle_cnt(cyc_b),
        .inst_cnt(inst_b), .br_cnt(brc_b), .br_hit(brh_b)
    );

    logic [1:0]  o_valid, o_ovf;
    logic [31:0] o_pc   [2];
    logic [4:0]  o_dest [2];
    logic [31:0] o_data [2];
    assign o_valid   = {bus_b.out_valid, bus_a.out_valid};
    assign o_ovf     = {ovf_b, ovf_a};
    assign o_pc[0]   = bus_a.out_pc;
    assign o_pc[1]   = bus_b.out_pc;
    assign o_dest[0] = bus_a.out_dest;
    assign o_dest[1] = bus_b.out_dest;
    assign o_data[0] = bus_a.out_wdata;
    assign o_data[1] = bus_b.out_wdata;

    int     errors = 0;
    int     checks = 0;
    entry_t sbq [2][$];
    int     depth_m [2] = '{16, 4};
    int     pops [2] = '{0, 0};
    logic   [1:0] ovf_m = 2'b00;
    logic   done_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
        return d & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic idle();
        cm_valid = '0; cm_br_op = '0; cm_pred_ok = '0;
        cm_pc = '0; cm_dest = '0; cm_wstrb = '0; cm_wdata = '0;
    endtask

    task automatic port(input int i, input logic [31:0] pc, input logic [4:0] dest,
                        input logic [3:0] strb, input logic [31:0] data,
                        input logic br, input logic ok);
        cm_valid[i]          = 1'b1;
        cm_pc[32*i +: 32]    = pc;
        cm_dest[5*i +: 5]    = dest;
        cm_wstrb[4*i +: 4]   = strb;
        cm_wdata[32*i +: 32] = data;
        cm_br_op[i]          = br;
        cm_pred_ok[i]        = ok;
    endtask

    // One clock: at the falling edge compare the outputs against the model, pop what the
    // DUT hands over, enqueue what this cycle's stimulus should push; then step past the edge.
    task automatic tick();
        entry_t ents [$];
        entry_t e;
        logic   hit;
        int     occ;
        @(negedge clk);
        if (reset) begin
            for (int k = 0; k < 2; k++) sbq[k].delete();
            ovf_m  = 2'b00;
            done_m = 1'b0;
        end else begin
            hit = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (cm_valid[i] && cm_pc[32*i +: 32] == END_PC) hit = 1'b1;
                if (cm_valid[i] && cm_wstrb[4*i +: 4] != 4'h0 && cm_dest[5*i +: 5] != 5'd0 &&
                    trace_en && !done_m) begin
                    e.pc   = cm_pc[32*i +: 32];
                    e.dest = cm_dest[5*i +: 5];
                    e.data = mask(cm_wdata[32*i +: 32], cm_wstrb[4*i +: 4]);
                    ents.push_back(e);
                end
            end
            chk("done_a", done_a, done_m);
            chk("done_b", done_b, done_m);
            for (int k = 0; k < 2; k++) begin
                occ = sbq[k].size();
                chk($sformatf("out_valid[%0d]", k), o_valid[k], occ != 0);
                chk($sformatf("overflow[%0d]", k), o_ovf[k], ovf_m[k]);
                if (o_valid[k] && ready[k] && occ != 0) begin
                    e = sbq[k].pop_front();
                    pops[k]++;
                    chk($sformatf("head_pc[%0d]", k), o_pc[k], e.pc);
                    chk($sformatf("head_dest[%0d]", k), o_dest[k], e.dest);
                    chk($sformatf("head_data[%0d]", k), o_data[k], e.data);
                end
                if (ents.size() != 0) begin
                    if (occ + ents.size() > depth_m[k]) ovf_m[k] = 1'b1;
                    else foreach (ents[j]) sbq[k].push_back(ents[j]);
                end
            end
            if (cnt_clear) begin
                done_m = 1'b0;
                ovf_m  = 2'b00;
            end else if (hit) begin
                done_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        idle();
        ready = 2'b11;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 40) begin
            tick();
            n++;
        end
        tick();
        chk({tag, "_left"}, sbq[0].size() + sbq[1].size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        reset = 1'b1; trace_en = 1'b1; cnt_clear = 1'b0; ready = 2'b00;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid_a", o_valid[0], 0);
        chk("rst_valid_b", o_valid[1], 0);
        chk("rst_pc_a", o_pc[0], 0);
        chk("rst_dest_a", o_dest[0], 0);
        chk("rst_data_a", o_data[0], 0);
        chk("rst_af_a", af_a, 0);
        chk("rst_af_b", af_b, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_cyc_a", cyc_a, 0);
        chk("rst_inst_a", inst_a, 0);
        chk("rst_br_a", brc_a, 0);
        chk("rst_hit_a", brh_a, 0);

        // Compaction and byte masking
        port(0, 32'hbfc00000, 5'd0, 4'hf, 32'hdeadbeef, 1'b0, 1'b0);
        port(1, 32'hbfc00004, 5'd3, 4'b0011, 32'h12345678, 1'b0, 1'b0);
        tick();
        idle();
        chk("cmp_valid", o_valid[0], 1);
        chk("cmp_pc", o_pc[0], 32'hbfc00004);
        chk("cmp_dest", o_dest[0], 3);
        chk("cmp_data", o_data[0], 32'h00005678);
        chk("cmp_data_b", o_data[1], 32'h00005678);
        drain("compact");

        // Ordering with continuous drain
        p = pops[0];
        chk("ord_pre_valid", o_valid[0], 0);
        for (int c = 0; c < 4; c++) begin
            port(0, 32'h00400000 + 8 * c, 5'(2 * c + 1), 4'hf, $urandom, 1'b0, 1'b0);
            port(1, 32'h00400004 + 8 * c, 5'(2 * c + 2), 4'hf, $urandom, 1'b0, 1'b0);
            tick();
            if (c == 0) chk("ord_valid_rise", o_valid[0], 1);
        end
        drain("order");
        chk("ord_count", pops[0] - p, 8);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;

        // Overflow on the 4-deep instance
        ready = 2'b01;
        p = pops[1];
        for (int s = 0; s < 3; s++) begin
            port(0, 32'h00500000 + 8 * s, 5'd4, 4'hf, $urandom, 1'b0, 1'b0);
            port(1, 32'h00500004 + 8 * s, 5'd6, 4'b1100, $urandom, 1'b0, 1'b0);
            tick();
            if (s == 0) chk("ovf_af_set1", af_b, 0);
            if (s == 1) chk("ovf_af_set2", af_b, 1);
        end
        idle();
        chk("ovf_flag", ovf_b, 1);
        chk("ovf_flag_a", ovf_a, 0);
        tick();
        chk("ovf_af_hold", af_b, 1);
        chk("ovf_head_stable", o_pc[1], 32'h00500000);
        drain("overflow");
        chk("ovf_count", pops[1] - p, 4);
        chk("ovf_af_clear", af_b, 0);

        // Pointer wrap with one push and one pop per cycle, plus a trace_en-gated cycle
        p = pops[1];
        for (int k = 0; k < 10; k++) begin
            idle();
            port(0, 32'h00800000 + 4 * k, 5'(k + 1), 4'($urandom_range(1, 15)), $urandom,
                 1'b0, 1'b0);
            tick();
        end
        trace_en = 1'b0;
        port(0, 32'h00880000, 5'd9, 4'hf, 32'h11111111, 1'b0, 1'b0);
        tick();
        trace_en = 1'b1;
        drain("wrap");
        chk("wrap_count", pops[1] - p, 10);

        // Counters and end PC
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        for (int c = 0; c < 6; c++) begin
            idle();
            port(0, 32'h00600000 + 8 * c, 5'd0, 4'hf, 32'h0, c == 0 || c == 4, c == 0);
            port(1, 32'h00600004 + 8 * c, 5'd0, 4'hf, 32'h0, c == 2, c == 2 || c == 1);
            tick();
        end
        idle();
        port(0, 32'h00600030, 5'd0, 4'hf, 32'h0, 1'b0, 1'b0);
        port(1, END_PC, 5'd7, 4'hf, 32'hcafef00d, 1'b0, 1'b0);
        tick();
        chk("end_done", done_a, 1);
        idle();
        port(0, 32'h00900000, 5'd9, 4'hf, 32'h22222222, 1'b1, 1'b1);
        port(1, 32'h00900004, 5'd10, 4'hf, 32'h33333333, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk("end_inst_a", inst_a, 14);
        chk("end_br_a", brc_a, 3);
        chk("end_hit_a", brh_a, 2);
        chk("end_cyc_a", cyc_a, 7);
        chk("end_inst_b", inst_b, 14);
        chk("end_cyc_b", cyc_b, 7);
        drain("end");

        // Saturation and clear priority
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        repeat (20) tick();
        chk("sat_cyc_b", cyc_b, 15);
        chk("sat_cyc_a", cyc_a, 20);
        cnt_clear = 1'b1;
        port(0, 32'h00700000, 5'd0, 4'hf, 32'h0, 1'b1, 1'b1);
        port(1, 32'h00700004, 5'd0, 4'hf, 32'h0, 1'b1, 1'b1);
        tick();
        cnt_clear = 1'b0;
        idle();
        chk("clr_cyc_a", cyc_a, 0);
        chk("clr_inst_a", inst_a, 0);
        chk("clr_br_a", brc_a, 0);
        chk("clr_hit_a", brh_a, 0);
        chk("clr_cyc_b", cyc_b, 0);

        // Reset with entries queued
        ready = 2'b00;
        port(0, 32'h00a00000, 5'd1, 4'hf, 32'h44444444, 1'b0, 1'b0);
        port(1, 32'h00a00004, 5'd2, 4'hf, 32'h55555555, 1'b0, 1'b0);
        tick();
        idle();
        port(0, 32'h00a00008, 5'd3, 4'hf, 32'h66666666, 1'b0, 1'b0);
        tick();
        idle();
        chk("pre_rst_valid", o_valid[0], 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst_valid_a", o_valid[0], 0);
        chk("post_rst_valid_b", o_valid[1], 0);
        chk("post_rst_pc_a", o_pc[0], 0);
        chk("post_rst_af_b", af_b, 0);
        ready = 2'b11;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_monitor.md
# commit_trace_monitor

Synthesizable, parametrised commit-side monitor for the N-wide ReMIPS pipeline. It sits beside the write-back stage and takes one debug commit bus per issue slot. Qualifying register writes are serialised in program order into a FIFO that drains through a valid/ready stream for trace comparison or UART/trace dump logic. It also maintains saturating IPC and branch-prediction counters, and freezes on reaching a programmed end PC.

## Interface
- `NUM_PORTS`, 2: commit slots; port 0 is oldest in program order.
- `DEPTH`, 16: FIFO entries; power of two, ≥ `NUM_PORTS`.
- `CNT_W`, 32: perf counter width.
- `END_PC`, 32'hbfc00100: PC that terminates monitoring.
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `trace_en`  in  1  enables FIFO pushes (confreg open_trace).
- `cnt_clear`  in  1  synchronous clear of counters, `done` and `overflow`; the FIFO is untouched.
- `cm_valid`  in  NUM_PORTS  commit valid per port.
- `cm_pc`  in  32*NUM_PORTS  commit PC; port i at [32i+31:32i].
- `cm_dest`  in  5*NUM_PORTS  destination register.
- `cm_wstrb`  in  4*NUM_PORTS  byte write strobes.
- `cm_wdata`  in  32*NUM_PORTS  write data.
- `cm_br_op`  in  NUM_PORTS  instruction is a branch.
- `cm_pred_ok`  in  NUM_PORTS  branch prediction was correct.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_pc`  out  32  head PC.
- `out_dest`  out  5  head destination register.
- `out_wdata`  out  32  head data, byte-masked.
- `almost_full`  out  1  free entries < NUM_PORTS, registered.
- `overflow`  out  1  sticky: at least one cycle's entries were dropped.
- `done`  out  1  sticky: END_PC committed.
- `cycle_cnt`, `inst_cnt`, `br_cnt`, `br_hit`  out  CNT_W each  performance counters.

## Operation
- Entry qualifies when `cm_valid[i] && cm_wstrb[i]!=0 && cm_dest[i]!=0 && trace_en && !done`.
- Stored data is `cm_wdata` with byte k zeroed when `wstrb[k]==0`.
- Qualifying entries of one cycle are pushed compacted, in ascending port order. Non-qualifying ports leave no gap.
- Acceptance is all-or-nothing per cycle. If `occupancy + n_qual > DEPTH`, with occupancy taken at the start of the cycle and a same-cycle pop not credited, no entry from that cycle is written, `overflow` is set, and nothing else changes.
- A pop happens when `out_valid && out_ready`. Push and pop in the same cycle are both honoured.
- Counters advance only while `!done`:
  - `cycle_cnt` += 1 per cycle.
  - `inst_cnt` += popcount(`cm_valid`).
  - `br_cnt` += popcount(`cm_valid & cm_br_op`).
  - `br_hit` += popcount(`cm_valid & cm_br_op & cm_pred_ok`).
- All counters saturate at 2^CNT_W−1; they never wrap.
- `done` is set in the cycle after any valid port presents `cm_pc == END_PC`. That cycle's commits are still counted and pushed. From the next cycle on, nothing is counted or pushed. The FIFO keeps draining.
- `cnt_clear` takes priority over same-cycle increments: counters become 0 and `done`/`overflow` become 0.
- `reset` empties the FIFO and resets all state, including a mid-drain FIFO. Outputs after reset: `out_valid`=0, `out_*` data=0, `almost_full`=0, `overflow`=0, `done`=0, all counters 0.

## Timing
- Push-to-`out_valid` latency is 1 cycle: an entry written at edge t is visible after t.
- Head outputs come straight from registered FIFO storage and stay stable while `out_valid && !out_ready`.
- Throughput: up to NUM_PORTS pushes and 1 pop per cycle.
- `almost_full` and the counters update on the same edge as the events that change them.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.

## Test plan
- **Compaction and masking:** with NUM_PORTS=2, port0 `{pc=bfc00000,dest=0}`, port1 `{pc=bfc00004,dest=3,wstrb=4'b0011,wdata=12345678}` → exactly one entry: `bfc00004`/`3`/`00005678`.
- **Ordering:** both ports qualify for 4 cycles with `out_ready=1` → 8 entries emerge in port0, port1 order per cycle; `out_valid` rises one cycle after the first push.
- **Overflow:** DEPTH=4, `out_ready=0`, push 2+2, then 2 more → third set dropped; `overflow`=1; `almost_full`=1 after the second set; occupancy stays 4; the first 4 entries drain intact.
- **Wrap:** DEPTH=4 with continuous push and pop across 10 entries → data intact across pointer wrap.
- **Counters and end:** 6 cycles of 2-valid commits, including 3 branches with 2 predicted correctly, then port1 `pc=bfc00100` → `done`=1; counters freeze at `inst_cnt`=14, `br_cnt`=3, `br_hit`=2, `cycle_cnt`=7.
- **Saturation, clear, reset:** CNT_W=4 and 20 cycles → `cycle_cnt`=15. Assert `cnt_clear` together with `valid=2'b11` → counters read 0. `reset` with 3 entries queued → `out_valid`=0 next cycle.
